// File: rtl/div_pkg.sv
// Shared types and constants for the divide sequencer and its testbench.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_READ,
        ST_DONE
    } state_t;

    // Operand slots in core data memory
    localparam logic [7:0]  ADDR_DVD_HI  = 8'd0;
    localparam logic [7:0]  ADDR_DVD_LO  = 8'd1;
    localparam logic [7:0]  ADDR_DVS     = 8'd2;
    // Default location of the three result bytes (MSB first)
    localparam logic [7:0]  RES_BASE_DEF = 8'd4;
    // Default number of RUN cycles granted to the core before giving up
    localparam logic [15:0] TIMEOUT_DEF  = 16'd4000;

    localparam int          LOAD_CYCLES  = 6;
    localparam int          READ_CYCLES  = 3;
    // A halt flag still high from the previous job is not trusted for this many RUN cycles
    localparam logic [15:0] HALT_IGNORE  = 16'd2;
    localparam logic [23:0] QUOT_DIV0    = 24'hFFFFFF;

    // Address/data pair {addr, data} written in LOAD slot idx
    function automatic logic [15:0] load_slot(
        input logic [2:0]  idx,
        input logic [15:0] dvd,
        input logic [7:0]  dvs,
        input logic [7:0]  base
    );
        logic [15:0] slot;
        slot = {base + 8'd2, 8'h00};
        case (idx)
            3'd0:    slot = {ADDR_DVD_HI, dvd[15:8]};
            3'd1:    slot = {ADDR_DVD_LO, dvd[7:0]};
            3'd2:    slot = {ADDR_DVS, dvs};
            3'd3:    slot = {base, 8'h00};
            3'd4:    slot = {base + 8'd1, 8'h00};
            default: slot = {base + 8'd2, 8'h00};
        endcase
        return slot;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; o_term flags that the next enabled tick reaches LIMIT.
// Latency: count updates one cycle after enable; o_term is combinational from the count.
// Backpressure: none; holds at LIMIT instead of wrapping.
module sat_counter #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] LIMIT = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count,
    output logic             o_term
);

    logic [WIDTH-1:0] r_count;

    // Count enabled cycles, clear has priority, stop at LIMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;
    assign o_term  = (r_count >= (LIMIT - {{(WIDTH-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/div_sequencer.sv
// Loads operands into a divide core's memory, launches it, waits for halt/timeout and reads back a 16.8 quotient.
// Latency: 6 load + RUN cycles + 3 read + 1 to res_valid; 1 cycle for a zero divisor.
// Backpressure: op_ready only in IDLE; result held in DONE until res_ready.
module div_sequencer
    import div_pkg::*;
#(
    parameter logic [15:0] TIMEOUT  = TIMEOUT_DEF,
    parameter logic [7:0]  RES_BASE = RES_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] op_dividend,
    input  logic [7:0]  op_divisor,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [23:0] res_quotient,
    output logic        res_err,
    output logic        core_start,
    input  logic        core_halt,
    output logic [7:0]  dm_addr,
    output logic        dm_wr_en,
    output logic [7:0]  dm_wr_data,
    input  logic [7:0]  dm_rd_data
);

    state_t      r_state;
    logic [2:0]  r_idx;
    logic [15:0] r_dvd;
    logic [7:0]  r_dvs;
    logic        r_op_ready;
    logic        r_res_vld;
    logic [23:0] r_quot;
    logic        r_err;
    logic        r_core_start;
    logic [7:0]  r_dm_addr;
    logic        r_dm_wr_en;
    logic [7:0]  r_dm_wr_data;

    logic [15:0] w_cnt;
    logic        w_term;
    logic        w_halt;
    logic [15:0] w_first;
    logic [15:0] w_next;

    // RUN-cycle counter: zero outside RUN, so RUN cycle k sees count k
    sat_counter #(
        .WIDTH (16),
        .LIMIT (TIMEOUT)
    ) u_run_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (r_state != ST_RUN),
        .i_enable (r_state == ST_RUN),
        .o_count  (w_cnt),
        .o_term   (w_term)
    );

    // Halt is only believed once the stale-flag window has passed
    assign w_halt  = core_halt && (w_cnt >= HALT_IGNORE);
    assign w_first = load_slot(3'd0, op_dividend, op_divisor, RES_BASE);
    assign w_next  = load_slot(r_idx + 3'd1, r_dvd, r_dvs, RES_BASE);

    // Sequencer FSM; every output is a register set on the transition that needs it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_dvd        <= '0;
            r_dvs        <= '0;
            r_op_ready   <= 1'b1;
            r_res_vld    <= 1'b0;
            r_quot       <= '0;
            r_err        <= 1'b0;
            r_core_start <= 1'b1;
            r_dm_addr    <= '0;
            r_dm_wr_en   <= 1'b0;
            r_dm_wr_data <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (op_valid && r_op_ready) begin
                        r_dvd      <= op_dividend;
                        r_dvs      <= op_divisor;
                        r_op_ready <= 1'b0;
                        r_idx      <= '0;
                        if (op_divisor == 8'd0) begin
                            r_state   <= ST_DONE;
                            r_res_vld <= 1'b1;
                            r_quot    <= QUOT_DIV0;
                            r_err     <= 1'b1;
                        end else begin
                            r_state                   <= ST_LOAD;
                            r_quot                    <= '0;
                            r_err                     <= 1'b0;
                            r_dm_wr_en                <= 1'b1;
                            {r_dm_addr, r_dm_wr_data} <= w_first;
                        end
                    end
                end
                ST_LOAD: begin
                    if (r_idx == 3'(LOAD_CYCLES - 1)) begin
                        r_state      <= ST_RUN;
                        r_dm_wr_en   <= 1'b0;
                        r_dm_addr    <= '0;
                        r_dm_wr_data <= '0;
                        r_core_start <= 1'b0;
                    end else begin
                        r_idx                     <= r_idx + 3'd1;
                        {r_dm_addr, r_dm_wr_data} <= w_next;
                    end
                end
                ST_RUN: begin
                    // Halt beats a simultaneous timeout
                    if (w_halt) begin
                        r_state      <= ST_READ;
                        r_core_start <= 1'b1;
                        r_dm_addr    <= RES_BASE;
                        r_idx        <= '0;
                    end else if (w_term) begin
                        r_state      <= ST_DONE;
                        r_core_start <= 1'b1;
                        r_quot       <= '0;
                        r_err        <= 1'b1;
                        r_res_vld    <= 1'b1;
                    end
                end
                ST_READ: begin
                    r_quot <= {r_quot[15:0], dm_rd_data};
                    if (r_idx == 3'(READ_CYCLES - 1)) begin
                        r_state   <= ST_DONE;
                        r_dm_addr <= '0;
                        r_res_vld <= 1'b1;
                        r_err     <= 1'b0;
                    end else begin
                        r_idx     <= r_idx + 3'd1;
                        r_dm_addr <= r_dm_addr + 8'd1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_state    <= ST_IDLE;
                        r_res_vld  <= 1'b0;
                        r_op_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign op_ready     = r_op_ready;
    assign res_valid    = r_res_vld;
    assign res_quotient = r_quot;
    assign res_err      = r_err;
    assign core_start   = r_core_start;
    assign dm_addr      = r_dm_addr;
    assign dm_wr_en     = r_dm_wr_en;
    assign dm_wr_data   = r_dm_wr_data;

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized self-checking bench for div_sequencer with a behavioural core + data memory.
// Latency: n/a (testbench).
// Backpressure: exercised by holding res_ready low for random/long stretches.
module tb_div_sequencer;
    import div_pkg::*;

    localparam logic [15:0] TO = 16'd100;
    localparam logic [7:0]  RB = 8'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] op_dividend = '0;
    logic [7:0]  op_divisor = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [23:0] res_quotient;
    logic        res_err;
    logic        core_start;
    logic        core_halt = 1'b1;
    logic [7:0]  dm_addr;
    logic        dm_wr_en;
    logic [7:0]  dm_wr_data;
    logic [7:0]  dm_rd_data;

    logic [7:0]  mem [256];
    logic [15:0] wr_log [$];
    int          halt_at = -1;
    int          run_k = 0;
    logic        prev_cs = 1'b1;
    int          n_chk = 0;
    int          n_err = 0;

    div_sequencer #(.TIMEOUT(TO), .RES_BASE(RB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_dividend  (op_dividend),
        .op_divisor   (op_divisor),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_quotient (res_quotient),
        .res_err      (res_err),
        .core_start   (core_start),
        .core_halt    (core_halt),
        .dm_addr      (dm_addr),
        .dm_wr_en     (dm_wr_en),
        .dm_wr_data   (dm_wr_data),
        .dm_rd_data   (dm_rd_data)
    );

    always #5 clk = ~clk;

    assign dm_rd_data = mem[dm_addr];

    // Memory and core model, evaluated mid-cycle. The core divides whatever the
    // sequencer stored, leaves its halt flag high after finishing, and only
    // drops the stale flag on its third cycle after a launch.
    always @(negedge clk) begin
        logic [23:0] num;
        logic [23:0] q;
        if (dm_wr_en) begin
            mem[dm_addr] = dm_wr_data;
            wr_log.push_back({dm_addr, dm_wr_data});
        end
        if (!core_start) begin
            run_k = prev_cs ? 0 : run_k + 1;
            if (run_k == halt_at) begin
                num = {mem[0], mem[1], 8'h00};
                q = (mem[2] == 8'd0) ? 24'h0 : num / {16'h0, mem[2]};
                mem[RB]        = q[23:16];
                mem[RB + 8'd1] = q[15:8];
                mem[RB + 8'd2] = q[7:0];
                core_halt = 1'b1;
            end else if (run_k >= 2) begin
                core_halt = 1'b0;
            end
        end
        prev_cs = core_start;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction: reference expectations come from plain arithmetic on the operands
    task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs, input int h_at, input int rdy_dly);
        int          exp_lat;
        int          n_wr;
        int          cyc;
        int          base;
        logic [23:0] exp_q;
        logic        exp_e;
        logic        rdy_bad;
        logic        cs_low;
        logic        stab_bad;
        logic [23:0] q0;
        logic        e0;
        logic [15:0] exp_w [6];

        if (dvs == 8'd0) begin
            exp_q = 24'hFFFFFF; exp_e = 1'b1; exp_lat = 1; n_wr = 0;
        end else if (h_at >= 2 && h_at < int'(TO)) begin
            exp_q = {dvd, 8'h00} / {16'h0, dvs}; exp_e = 1'b0;
            exp_lat = 6 + (h_at + 1) + 3 + 1; n_wr = 6;
        end else begin
            exp_q = 24'h0; exp_e = 1'b1; exp_lat = 6 + int'(TO) + 1; n_wr = 6;
        end
        exp_w[0] = {8'd0, dvd[15:8]};
        exp_w[1] = {8'd1, dvd[7:0]};
        exp_w[2] = {8'd2, dvs};
        exp_w[3] = {RB, 8'h00};
        exp_w[4] = {RB + 8'd1, 8'h00};
        exp_w[5] = {RB + 8'd2, 8'h00};

        halt_at = h_at;
        @(posedge clk); #1;
        op_valid = 1'b1; op_dividend = dvd; op_divisor = dvs;
        base = wr_log.size();
        chk("op_ready_idle", {31'd0, op_ready}, 32'd1);
        @(posedge clk); #1;
        op_valid = 1'b0; op_dividend = 16'($urandom); op_divisor = 8'($urandom);
        cyc = 1; rdy_bad = 1'b0; cs_low = 1'b0;
        while (!res_valid && cyc < exp_lat + 20) begin
            if (op_ready)    rdy_bad = 1'b1;
            if (!core_start) cs_low  = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, exp_lat);
        chk("quotient", {8'd0, res_quotient}, {8'd0, exp_q});
        chk("err", {31'd0, res_err}, {31'd0, exp_e});
        chk("op_ready_busy", {31'd0, rdy_bad}, 32'd0);
        chk("core_launched", {31'd0, cs_low}, (dvs != 8'd0) ? 32'd1 : 32'd0);
        chk("core_start_done", {31'd0, core_start}, 32'd1);
        chk("dm_addr_done", {24'd0, dm_addr}, 32'd0);
        chk("wr_count", wr_log.size() - base, n_wr);
        for (int i = 0; i < n_wr && base + i < wr_log.size(); i++) begin
            chk($sformatf("wr%0d", i), {16'd0, wr_log[base + i]}, {16'd0, exp_w[i]});
        end

        q0 = res_quotient; e0 = res_err; stab_bad = 1'b0;
        repeat (rdy_dly) begin
            @(posedge clk); #1;
            if (!res_valid || res_quotient !== q0 || res_err !== e0 || op_ready) stab_bad = 1'b1;
        end
        chk("hold_stable", {31'd0, stab_bad}, 32'd0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("res_valid_drop", {31'd0, res_valid}, 32'd0);
        chk("op_ready_back", {31'd0, op_ready}, 32'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_op_ready"}, {31'd0, op_ready}, 32'd1);
        chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_quot"}, {8'd0, res_quotient}, 32'd0);
        chk({tag, "_err"}, {31'd0, res_err}, 32'd0);
        chk({tag, "_core_start"}, {31'd0, core_start}, 32'd1);
        chk({tag, "_wr_en"}, {31'd0, dm_wr_en}, 32'd0);
        chk({tag, "_addr"}, {24'd0, dm_addr}, 32'd0);
    endtask

    initial begin
        int          base;
        logic [15:0] dvd;
        logic [7:0]  dvs;
        int          sel;
        int          h;

        #12;
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        // Directed: worked example, stale halt from reset is high at launch
        run_op(16'hFFFF, 8'h02, 49, 0);
        // Zero divisor
        run_op(16'h1234, 8'h00, 10, 1);
        // Core never halts
        run_op(16'h0100, 8'h03, -1, 0);
        // Halt in the very last RUN cycle beats the timeout
        run_op(16'hABCD, 8'h07, int'(TO) - 1, 0);
        // Earliest halt the sequencer may honour, then a long consumer stall
        run_op(16'h0001, 8'hFF, 2, 0);
        run_op(16'h1234, 8'h10, 20, 20);

        // Reset during LOAD after three writes
        halt_at = 10;
        @(posedge clk); #1;
        op_valid = 1'b1; op_dividend = 16'h5A5A; op_divisor = 8'h05;
        base = wr_log.size();
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("wr_before_rst", wr_log.size() - base, 3);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        repeat (3) @(posedge clk);
        chk("wr_during_rst", wr_log.size() - base, 3);
        #2;
        rst_n = 1'b1;
        run_op(16'h5A5A, 8'h05, 10, 2);

        // Randomized transactions
        for (int i = 0; i < 12; i++) begin
            dvd = 16'($urandom);
            dvs = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            sel = $urandom_range(0, 9);
            h = (sel == 0) ? -1 : (sel == 1) ? int'(TO) - 1 : (sel == 2) ? int'(TO) : $urandom_range(2, 60);
            run_op(dvd, dvs, h, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd4000: max cycles to wait for core halt.
REQ-002 SHALL have parameter RES_BASE, default 8'd4: data-memory address of the quotient MSB.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 op_valid  input  1  operand request valid.
REQ-006 op_ready  output  1  sequencer can accept an operand.
REQ-007 op_dividend  input  16  unsigned dividend.
REQ-008 op_divisor  input  8  unsigned divisor.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer accepts result.
REQ-011 res_quotient  output  24  unsigned 16.8 fixed-point quotient, {mem[RES_BASE], mem[RES_BASE+1], mem[RES_BASE+2]}.
REQ-012 res_err  output  1  1 = divide-by-zero or timeout.
REQ-013 core_start  output  1  core hold/launch; high holds the core, a falling edge launches it.
REQ-014 core_halt  input  1  core done flag.
REQ-015 dm_addr  output  8  data-memory address.
REQ-016 dm_wr_en  output  1  data-memory write strobe.
REQ-017 dm_wr_data  output  8  write data.
REQ-018 dm_rd_data  input  8  combinational read data for dm_addr, same cycle.

Function
REQ-019 SHALL implement states IDLE, LOAD, RUN, READ, DONE.
REQ-020 IDLE: op_ready=1, core_start=1; op_valid&op_ready latches operands and moves to LOAD, or to DONE with res_err=1 and quotient 24'hFFFFFF if divisor==0.
REQ-021 LOAD: 6 cycles, one write per cycle, in order: addr0=dividend[15:8], addr1=dividend[7:0], addr2=divisor, RES_BASE..RES_BASE+2=0; core_start stays 1.
REQ-022 RUN: core_start=0; cycle counter starts at 0; core_halt SHALL be ignored for the first 2 RUN cycles (stale halt), then sampled each cycle.
REQ-023 RUN -> READ on sampled core_halt=1; RUN -> DONE with res_err=1 and quotient 0 when the counter reaches TIMEOUT; halt and timeout in the same cycle -> halt wins.
REQ-024 READ: 3 cycles, dm_addr=RES_BASE, +1, +2; dm_rd_data captured into quotient bytes MSB-first; core_start returns to 1 on entry.
REQ-025 DONE: res_valid=1; res_quotient/res_err stable until res_valid&res_ready, then IDLE.
REQ-026 op_ready SHALL be 0 in every state except IDLE; operands are sampled only on handshake.
REQ-027 dm_wr_en SHALL be 1 only in LOAD; dm_addr is 0 in states without memory access.
REQ-028 Latency from op handshake to res_valid SHALL be 6 + RUN cycles + 3 + 1 for a normal run, and 1 cycle for divisor 0.
REQ-029 The counter SHALL saturate and never wrap.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, op_ready=1, res_valid=0, res_quotient=0, res_err=0, core_start=1, dm_wr_en=0, dm_addr=0, counter=0.
REQ-031 Reset mid-operation SHALL abandon the transaction with no result and no further memory writes.

Structure
REQ-032 The state enum, memory address constants (addr 0/1/2, RES_BASE) and the default TIMEOUT SHALL live in a shared package, div_pkg.
REQ-033 The timeout counter SHALL be a sub-module, sat_counter (clear, enable, terminal flag).

Verification
REQ-034 Operands 0xFFFF/0x02, core model halts after 50 cycles with mem4..6=7F,FF,80 -> res_quotient=24'h7FFF80, res_err=0.
REQ-035 Divisor 0x00 -> res_valid one cycle after handshake, res_quotient=24'hFFFFFF, res_err=1, no dm_wr_en pulses, core_start stays 1.
REQ-036 Core never halts, TIMEOUT=100 -> res_err=1, res_quotient=0 exactly 100 RUN cycles after entering RUN.
REQ-037 core_halt held high from the previous run -> not sampled in the first 2 RUN cycles; result is read only after the new halt.
REQ-038 res_ready held low 20 cycles -> res_valid and data stable, op_ready=0 throughout.
REQ-039 rst_n asserted during LOAD after 3 writes -> immediate IDLE outputs, no further writes; the next transaction completes correctly.
